// File: rtl/i2c_globals_pkg.sv
// Shared I2C definitions: default target address, ACK / R/W encodings and
// the state encoding of the slave responder FSM.
package i2c_globals_pkg;

    localparam logic [6:0] SLAVE0_ADDRESS = 7'h68;

    typedef enum logic {
        POS_ACK = 1'b0,
        NEG_ACK = 1'b1
    } acknowledge_e;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } read_write_e;

    typedef enum logic [4:0] {
        IDLE      = 5'd0,
        ADDR      = 5'd1,
        ADDR_ACK  = 5'd2,
        REG_ADDR  = 5'd3,
        REG_ACK   = 5'd4,
        WR_DATA   = 5'd5,
        WR_ACK    = 5'd6,
        RD_DATA   = 5'd7,
        RD_ACK    = 5'd8,
        WAIT_STOP = 5'd9
    } i2c_slave_state_e;

endpackage

// File: rtl/i2c_line_sampler.sv
// Brings one open-drain bus line into the pclk domain and produces its
// settled level plus single-cycle rise/fall strobes.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter
// after the synchronizer (1-pclk pulses vanish, event latency 3 -> 5 pclk).
module i2c_line_sampler (
    input  logic pclk,
    input  logic areset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_1, sync_2, hist, level_int;

    // Two-flop synchronizer; resets to the idle (released, high) bus level.
    always_ff @(posedge pclk) begin
        if (!areset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic tap_1, tap_2, filt;

    // Majority of three consecutive synchronized samples.
    always_ff @(posedge pclk) begin
        if (!areset) begin
            tap_1 <= 1'b1;
            tap_2 <= 1'b1;
            filt  <= 1'b1;
        end else begin
            tap_1 <= sync_2;
            tap_2 <= tap_1;
            filt  <= (sync_2 & tap_1) | (sync_2 & tap_2) | (tap_1 & tap_2);
        end
    end

    assign level_int = filt;
`else
    assign level_int = sync_2;
`endif

    // History flop for edge detection.
    always_ff @(posedge pclk) begin
        if (!areset) begin
            hist <= 1'b1;
        end else begin
            hist <= level_int;
        end
    end

    assign level = level_int;
    assign rise  = level_int & ~hist;
    assign fall  = ~level_int & hist;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a small register file: address match + ACK, register-
// addressed writes and (combined) reads with auto-incrementing pointer.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN enables line glitch filtering
// inside each i2c_line_sampler.
module i2c_slave_responder
    import i2c_globals_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = SLAVE0_ADDRESS,
    parameter int         NO_OF_REG     = 4,
    parameter int         DATA_WIDTH    = 8
) (
    input  logic       pclk,
    input  logic       areset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_strobe_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o,
    output logic [4:0] state_o
);

    localparam int PTR_W = (NO_OF_REG > 1) ? $clog2(NO_OF_REG) : 1;

    generate
        if (DATA_WIDTH != 8) begin : g_bad_width
            $error("i2c_slave_responder: DATA_WIDTH must be 8");
        end
    endgenerate

    i2c_slave_state_e        state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              shift_q, shift_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    sda_oe_q, sda_oe_d;
    logic                    busy_q, busy_d;
    read_write_e             rw_q, rw_d;
    acknowledge_e            ack_q, ack_d;
    logic                    wr_en;
    logic                    wr_strobe_q;
    logic [7:0]              wr_addr_q, wr_data_q;
    logic [DATA_WIDTH-1:0]   regs [NO_OF_REG];

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;
    logic [7:0] rd_byte;
    logic [2:0] bit_idx;

    i2c_line_sampler u_scl (
        .pclk  (pclk),
        .areset(areset),
        .pin   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sampler u_sda (
        .pclk  (pclk),
        .areset(areset),
        .pin   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rd_byte   = regs[ptr_q];
    assign bit_idx   = 3'(4'd7 - bit_cnt_q);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NO_OF_REG - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state and datapath decisions; bus conditions override everything.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        wr_en     = 1'b0;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            if (scl_rise && (state_q == ADDR || state_q == REG_ADDR || state_q == WR_DATA)) begin
                shift_d   = {shift_q[6:0], sda_lvl};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (state_q)
                ADDR: if (scl_fall && bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    if (shift_q[7:1] == SLAVE_ADDRESS) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        rw_d     = read_write_e'(shift_q[0]);
                        state_d  = ADDR_ACK;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (rw_q == WRITE) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = REG_ADDR;
                    end else begin
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 4'd1;
                        state_d   = RD_DATA;
                    end
                end
                REG_ADDR: if (scl_fall && bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    if (32'(shift_q) < NO_OF_REG) begin
                        ptr_d    = shift_q[PTR_W-1:0];
                        sda_oe_d = 1'b1;
                        state_d  = REG_ACK;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = WAIT_STOP;
                    end
                end
                REG_ACK: if (scl_fall) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = WR_DATA;
                end
                WR_DATA: if (scl_fall && bit_cnt_q == 4'd8) begin
                    sda_oe_d = 1'b1;
                    wr_en    = 1'b1;
                    state_d  = WR_ACK;
                end
                WR_ACK: if (scl_fall) begin
                    sda_oe_d  = 1'b0;
                    ptr_d     = ptr_inc(ptr_q);
                    bit_cnt_d = '0;
                    state_d   = WR_DATA;
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = RD_ACK;
                    end else begin
                        sda_oe_d  = ~rd_byte[bit_idx];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ack_d = acknowledge_e'(sda_lvl);
                        if (!sda_lvl) ptr_d = ptr_inc(ptr_q);
                    end else if (scl_fall) begin
                        if (ack_q == POS_ACK) begin
                            sda_oe_d  = ~rd_byte[7];
                            bit_cnt_d = 4'd1;
                            state_d   = RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, datapath and register-file storage.
    always_ff @(posedge pclk) begin
        if (!areset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= WRITE;
            ack_q       <= POS_ACK;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < NO_OF_REG; i++) regs[i] <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            wr_strobe_q <= wr_en;
            if (wr_en) begin
                regs[ptr_q] <= shift_q;
                wr_addr_q   <= 8'(ptr_q);
                wr_data_q   <= shift_q;
            end
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy_o      = busy_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign state_o     = state_q;

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- RTL I2C target (slave) for the I2C AVIP: responds to master-initiated transfers on an open-drain SCL/SDA pair.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs. Supports register-addressed writes and reads into a small internal register file.
- Acts as the DUT counterpart for the master agent. Also serves as a reference slave in the env.

Parameters:
- SLAVE_ADDRESS, 7'h68, this target's 7-bit address (package SLAVE0_ADDRESS).
- NO_OF_REG, 4, number of DATA_WIDTH registers (1..256).
- DATA_WIDTH, 8, register/byte width. Fixed at 8; any other value raises an elaboration error.

Ports:
- pclk  input  1  system clock; at least 8x the SCL rate.
- areset  input  1  synchronous, active-low reset.
- scl_i  input  1  sampled SCL line (asynchronous to pclk).
- sda_i  input  1  sampled SDA line (asynchronous to pclk).
- sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain).
- wr_strobe_o  output  1  one-pclk pulse per register written.
- wr_addr_o  output  8  register index of the last write.
- wr_data_o  output  8  data of the last write.
- busy_o  output  1  high from an address match until STOP.
- state_o  output  5  current FSM state, for debug/coverage.

Behaviour:
- Reset (areset=0 at a pclk edge):
  - sda_oe=0, wr_strobe_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, state=IDLE.
  - Register pointer=0; all registers=0.
  - Reset mid-transfer releases SDA on the next edge and the FSM returns to IDLE.
- Sampling:
  - 2-flop synchronizer on scl_i and sda_i, plus one history flop each.
  - scl_rise/scl_fall are edge strobes on the synchronized signals.
  - Latency from a pin edge to the internal event: 3 pclk.
- Bus conditions (checked every cycle in every state):
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - START in any state, including repeated START, goes to ADDR, clears the bit counter and releases SDA.
  - STOP in any state goes to IDLE, releases SDA and clears busy_o.
- Data timing:
  - Bits are sampled on scl_rise, MSB first.
  - The slave changes sda_oe only on scl_fall.
- FSM states: IDLE, ADDR, ADDR_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits (7 address bits + R/W).
    - On the 8th scl_fall: on a match, sda_oe=1, busy_o=1, next ADDR_ACK.
    - On a mismatch: next WAIT_STOP, SDA never driven.
  - ADDR_ACK: on the 9th scl_fall, sda_oe takes the next value below.
    - Write: sda_oe=0, next REG_ADDR.
    - Read: sda_oe=~reg[ptr][7], next RD_DATA.
  - REG_ADDR: shifts in 8 bits.
    - Index < NO_OF_REG: ptr=index, ACK, next REG_ACK.
    - Otherwise: NACK (SDA released), next WAIT_STOP.
  - REG_ACK: release SDA on scl_fall, next WR_DATA.
  - WR_DATA: on the 8th bit, ACK and go to WR_ACK.
    - The same pclk writes reg[ptr], pulses wr_strobe_o and updates wr_addr_o/wr_data_o.
  - WR_ACK: release SDA on scl_fall.
    - ptr = (ptr+1) mod NO_OF_REG, wrapping to 0 after NO_OF_REG-1.
    - Next WR_DATA.
  - RD_DATA: drives the bits of reg[ptr], updating on each scl_fall.
    - After the 8th bit's scl_fall, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's bit on scl_rise.
    - ACK (0): ptr increments with wrap; on scl_fall drive the MSB of the next register, next RD_DATA.
    - NACK (1): SDA stays released, next WAIT_STOP.
  - WAIT_STOP: ignores data; only START/STOP exit.
- Simultaneous events: a START/STOP detected in the same cycle as scl_fall takes priority.
- Read without a preceding register write uses the retained ptr (0 after reset).

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows each synchronizer. Pulses of 1 pclk are suppressed. Latency rises to 5 pclk.
- Undefined: no filter; 3-pclk latency as above.

Decomposition:
- Add to i2c_globals_pkg: typedef enum i2c_slave_state_e (the states above), and reuse acknowledge_e and read_write_e.
- Sub-module i2c_line_sampler, one instance per line: synchronizer, optional filter, rise/fall strobes.
- START/STOP detection and the FSM stay in i2c_slave_responder.

Test Plan:
- Write: START, 0xD0, 0x02, 0xA5, STOP.
  - ACK on all three bytes; reg[2]=0xA5; one wr_strobe_o with wr_addr_o=2 and wr_data_o=0xA5.
  - busy_o drops 3 pclk after STOP.
- Combined read: START, 0xD0, 0x02, repeated START, 0xD1.
  - Slave returns 0xA5. Master ACKs, slave returns reg[3]=0x00. Master NACKs, then STOP.
  - SDA is released after the NACK.
- Address mismatch: START, 0x98 (7'h4C write).
  - sda_oe stays 0 for the whole transfer; state_o reaches WAIT_STOP; busy_o=0.
- Wrap and out of range:
  - Write 4 bytes from reg 3: reg[3], reg[0], reg[1], reg[2] are written in that order.
  - Register index 0x04 gets a NACK, and no write strobe occurs.
- Reset mid-read: assert areset while the slave drives a 0 bit.
  - sda_oe=0 on the next pclk and state=IDLE.
  - The next START with 0xD0 gets an ACK.
- With I2C_SLAVE_GLITCH_FILTER_EN:
  - A 1-pclk low glitch on SDA while SCL is high does not produce a START or STOP.
  - Without the macro, the same glitch is detected as START.
